// File: rtl/memlcd_panel_rx.sv
// Panel-side memory-LCD receiver: decodes GSP/BSP/BCK/RGB into a pixel stream with position tags.
// Optional frame CRC-16-CCITT over emitted words when MEMLCD_RX_CRC_EN is defined.
module memlcd_panel_rx #(
  parameter int DATA_WIDTH = 6,
  parameter int H_ACTIVE   = 120,
  parameter int V_ACTIVE   = 640
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_intb,
  input  logic                  i_gsp,
  input  logic                  i_gck,
  input  logic                  i_gen,
  input  logic                  i_bsp,
  input  logic                  i_bck,
  input  logic [DATA_WIDTH-1:0] i_rgb,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [6:0]            o_col,
  output logic [9:0]            o_line,
  output logic                  o_sof,
  output logic                  o_eol,
  output logic                  o_frame_done,
  output logic                  o_err_short,
  output logic                  o_err_frame,
  output logic [15:0]           o_crc
);

  typedef enum logic [1:0] {IDLE, WAIT_BSP, DUMMY, PIXELS} state_t;

  localparam logic [6:0] COL_LAST  = 7'(H_ACTIVE - 1);
  localparam logic [9:0] LINE_LAST = 10'(V_ACTIVE - 1);

  logic                  gsp_p0, bsp_p0, bck_p0;
  logic                  gsp_p1, bsp_p1, bck_p1;
  logic [DATA_WIDTH-1:0] rgb_p0, rgb_p2;
  logic                  gsp_rise_p2, bsp_rise_p2, bck_edge_p2;

  state_t     state_q;
  logic [6:0] col_q;
  logic [9:0] line_q;
  logic       first_q;
  logic       done_q;
  logic       emit;

  // INTB/GCK/GEN are bus-monitor inputs only; they take no part in decoding.
  logic unused_monitor;
  assign unused_monitor = &{1'b0, i_intb, i_gck, i_gen};

  // Stage p0/p1: bus sample and previous sample, free-running so edge history survives reset
  always_ff @(posedge i_clk) begin
    gsp_p0 <= i_gsp;
    bsp_p0 <= i_bsp;
    bck_p0 <= i_bck;
    rgb_p0 <= i_rgb;
    gsp_p1 <= gsp_p0;
    bsp_p1 <= bsp_p0;
    bck_p1 <= bck_p0;
    rgb_p2 <= rgb_p0;
  end

  // Stage p2: registered bus events
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      gsp_rise_p2 <= 1'b0;
      bsp_rise_p2 <= 1'b0;
      bck_edge_p2 <= 1'b0;
    end else begin
      gsp_rise_p2 <= gsp_p0 & ~gsp_p1;
      bsp_rise_p2 <= bsp_p0 & ~bsp_p1;
      bck_edge_p2 <= bck_p0 ^ bck_p1;
    end
  end

  assign emit = (state_q == PIXELS) && bck_edge_p2 && !gsp_rise_p2 && !bsp_rise_p2;

  // Decode FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      line_q       <= '0;
      first_q      <= 1'b0;
      done_q       <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_col        <= '0;
      o_line       <= '0;
      o_sof        <= 1'b0;
      o_eol        <= 1'b0;
      o_frame_done <= 1'b0;
      o_err_short  <= 1'b0;
      o_err_frame  <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_sof        <= 1'b0;
      o_eol        <= 1'b0;
      o_frame_done <= 1'b0;
      o_err_short  <= 1'b0;
      o_err_frame  <= 1'b0;
      if (gsp_rise_p2) begin
        o_err_frame <= (state_q != IDLE);
        state_q     <= WAIT_BSP;
        line_q      <= '0;
        first_q     <= 1'b1;
        done_q      <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // A line start after a completed frame means the driver overran V_ACTIVE.
            if (bsp_rise_p2 && done_q) o_err_frame <= 1'b1;
          end
          WAIT_BSP: begin
            if (bsp_rise_p2) state_q <= DUMMY;
          end
          DUMMY: begin
            if (bsp_rise_p2) begin
              o_err_short <= 1'b1;
            end else if (bck_edge_p2) begin
              state_q <= PIXELS;
              col_q   <= '0;
            end
          end
          PIXELS: begin
            if (bsp_rise_p2) begin
              o_err_short <= 1'b1;
              state_q     <= DUMMY;
            end else if (bck_edge_p2) begin
              o_valid <= 1'b1;
              o_data  <= rgb_p2;
              o_col   <= col_q;
              o_line  <= line_q;
              o_sof   <= first_q;
              first_q <= 1'b0;
              if (col_q == COL_LAST) begin
                o_eol <= 1'b1;
                if (line_q == LINE_LAST) begin
                  o_frame_done <= 1'b1;
                  done_q       <= 1'b1;
                  state_q      <= IDLE;
                end else begin
                  line_q  <= line_q + 10'd1;
                  state_q <= WAIT_BSP;
                end
              end else begin
                col_q <= col_q + 7'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef MEMLCD_RX_CRC_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] byte_in);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ byte_in[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [15:0] crc_q;

  // Restart from the seed on the first word of a frame, otherwise accumulate.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_q <= 16'hFFFF;
    end else if (emit) begin
      crc_q <= crc16_byte(first_q ? 16'hFFFF : crc_q, 8'(rgb_p2));
    end
  end

  assign o_crc = crc_q;
`else
  assign o_crc = 16'h0000;
`endif

endmodule
